// File: rtl/mcp3202_sample_scheduler.sv
// Purpose : frame-driven conversion scheduler for a triggered MCP3202 SPI master; serves CH0/CH1 each
//           frame, lends idle ADC time to a host one-shot port, tags results, flags overrun/timeout.
// Latency : IDLE select -> spi_start 1 cycle; spi_dv -> smp_vld 1 cycle.
// Backpressure: none on results (smp_vld is a pulse); host_req is a level held until host_gnt.
// Ports   : clk/rst_n (async active-low); en gates the frame timer; host_req/host_ch/host_sgl/host_gnt
//           host request; spi_start/spi_sgl/spi_odd/spi_dv/spi_data SPI master handshake;
//           smp_vld/smp_data/smp_ch/smp_src tagged result; ovr/tmo sticky errors, err_clr clears them.
// Option  : define MCP_SCHED_TIMESTAMP_EN to add smp_ts[15:0], the frame index of each result.
module mcp3202_sample_scheduler #(
  parameter int       FCLK        = 100_000_000,
  parameter int       FSMPL       = 500,
  parameter bit [1:0] CH_MASK     = 2'b11,
  parameter bit       SGL         = 1'b1,
  parameter int       TIMEOUT_CYC = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        host_req,
  input  logic        host_ch,
  input  logic        host_sgl,
  output logic        host_gnt,
  output logic        spi_start,
  output logic        spi_sgl,
  output logic        spi_odd,
  input  logic        spi_dv,
  input  logic [11:0] spi_data,
  output logic        smp_vld,
  output logic [11:0] smp_data,
  output logic        smp_ch,
  output logic        smp_src,
  output logic        ovr,
  output logic        tmo,
  input  logic        err_clr
`ifdef MCP_SCHED_TIMESTAMP_EN
  ,
  output logic [15:0] smp_ts
`endif
);

  localparam int FRAME_CYC = FCLK / FSMPL;
  localparam int CNT_W     = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam int TMO_W     = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [TMO_W-1:0] tcnt_q, tcnt_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       consume;
  logic [1:0]       pend_rem;
  logic             ch_q, ch_d;
  logic             sgl_q, sgl_d;
  logic             src_q, src_d;
  logic [11:0]      data_q, data_d;
  logic             ovr_q, ovr_d;
  logic             tmo_q, tmo_d;
  logic             tick;
  logic             tmo_set;
  logic             sel;

  // Frame timer: held at zero while disabled so the first tick lands a full frame after en rises.
  always_comb begin
    tick   = en && (fcnt_q == CNT_W'(FRAME_CYC - 1));
    fcnt_d = (!en || tick) ? '0 : fcnt_q + CNT_W'(1);
  end

  // Conversion sequencer. Pending channels always win over the host, CH0 before CH1.
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    ch_d      = ch_q;
    sgl_d     = sgl_q;
    src_d     = src_q;
    data_d    = data_q;
    consume   = 2'b00;
    sel       = 1'b0;
    host_gnt  = 1'b0;
    spi_start = 1'b0;
    smp_vld   = 1'b0;
    tmo_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q[0]) begin
          consume = 2'b01; sel = 1'b1; ch_d = 1'b0; sgl_d = SGL; src_d = 1'b0;
        end else if (pend_q[1]) begin
          consume = 2'b10; sel = 1'b1; ch_d = 1'b1; sgl_d = SGL; src_d = 1'b0;
        end else if (host_req) begin
          host_gnt = 1'b1; sel = 1'b1; ch_d = host_ch; sgl_d = host_sgl; src_d = 1'b1;
        end
        if (sel) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        spi_start = 1'b1;
        tcnt_d    = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // A word arriving on the last allowed cycle still counts as on time.
        if (spi_dv) begin
          data_d  = spi_data;
          state_d = S_DONE;
        end else if (tcnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          tmo_set = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TMO_W'(1);
        end
      end
      S_DONE: begin
        smp_vld = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pending bookkeeping: a bit consumed on the tick cycle is re-armed without counting as overrun.
  always_comb begin
    pend_rem = pend_q & ~consume;
    pend_d   = en ? (pend_rem | (tick ? CH_MASK : 2'b00)) : 2'b00;
    ovr_d    = (tick && (pend_rem != 2'b00)) || (ovr_q && !err_clr);
    tmo_d    = tmo_set || (tmo_q && !err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      fcnt_q  <= '0;
      tcnt_q  <= '0;
      pend_q  <= 2'b00;
      ch_q    <= 1'b0;
      sgl_q   <= 1'b0;
      src_q   <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      tcnt_q  <= tcnt_d;
      pend_q  <= pend_d;
      ch_q    <= ch_d;
      sgl_q   <= sgl_d;
      src_q   <= src_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef MCP_SCHED_TIMESTAMP_EN
  // Frame index counts ticks; each conversion takes the index current when it was selected.
  logic [15:0] frm_q, ts_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_q <= '0;
      ts_q  <= '0;
    end else begin
      if (tick) frm_q <= frm_q + 16'd1;
      if (sel)  ts_q  <= frm_q;
    end
  end
  assign smp_ts = ts_q;
`endif

  assign spi_sgl  = sgl_q;
  assign spi_odd  = ch_q;
  assign smp_ch   = ch_q;
  assign smp_src  = src_q;
  assign smp_data = data_q;
  assign ovr      = ovr_q;
  assign tmo      = tmo_q;

endmodule
